// File: rtl/score_display.sv
// Game lifecycle tracker with BCD current/high score and a multiplexed
// 4-digit active-low 7-segment driver; game_clk and game_over enter via synchronisers.
module score_display #(
    parameter int FRAMES_PER_POINT = 6,
    parameter int REFRESH_DIV      = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_clk,
    input  logic        start,
    input  logic        game_over,
    input  logic        show_high,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic [1:0]  phase,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t         state_reg, state_next;
    logic           gclk_meta_reg, gclk_sync_reg, gclk_prev_reg, tick_reg;
    logic           go_meta_reg, go_sync_reg;
    logic [7:0]     div_reg;
    logic [15:0]    score_reg, high_reg;
    logic [RW-1:0]  refresh_reg;
    logic [1:0]     idx_reg;
    logic [3:0]     an_reg;
    logic [7:0]     seg_reg;

    // Ripple BCD +1 across the four digits
    logic [15:0] inc_bcd;
    logic [4:0]  carry;
    logic [15:0] shown;
    logic [3:0]  nz_above;
    assign carry[0] = 1'b1;
    assign shown    = show_high ? high_reg : score_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign inc_bcd[4*gi +: 4] = carry[gi]
                ? ((score_reg[4*gi +: 4] == 4'd9) ? 4'd0 : score_reg[4*gi +: 4] + 4'd1)
                : score_reg[4*gi +: 4];
            assign carry[gi+1] = carry[gi] & (score_reg[4*gi +: 4] == 4'd9);
            // Nonzero at or above this digit; zero means the digit is a leading zero
            assign nz_above[gi] = |shown[15:4*gi];
        end
    endgenerate

    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_code;
    assign digit = shown[4*idx_reg +: 4];
    assign blank = (idx_reg != 2'd0) && !nz_above[idx_reg];

    always_comb begin
        seg_code = 7'h7F;
        case (digit)
            4'd0: seg_code = 7'b1000000;
            4'd1: seg_code = 7'b1111001;
            4'd2: seg_code = 7'b0100100;
            4'd3: seg_code = 7'b0110000;
            4'd4: seg_code = 7'b0011001;
            4'd5: seg_code = 7'b0010010;
            4'd6: seg_code = 7'b0000010;
            4'd7: seg_code = 7'b1111000;
            4'd8: seg_code = 7'b0000000;
            4'd9: seg_code = 7'b0010000;
            default: seg_code = 7'h7F;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ARMED;
            ARMED:   if (tick_reg && !go_sync_reg) state_next = RUNNING;
            RUNNING: if (go_sync_reg) state_next = OVER;
            OVER:    if (start) state_next = ARMED;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gclk_meta_reg <= 1'b0;
            gclk_sync_reg <= 1'b0;
            gclk_prev_reg <= 1'b0;
            tick_reg      <= 1'b0;
            go_meta_reg   <= 1'b0;
            go_sync_reg   <= 1'b0;
            state_reg     <= IDLE;
            div_reg       <= 8'd0;
            score_reg     <= 16'h0000;
            high_reg      <= 16'h0000;
        end else begin
            gclk_meta_reg <= game_clk;
            gclk_sync_reg <= gclk_meta_reg;
            gclk_prev_reg <= gclk_sync_reg;
            tick_reg      <= gclk_sync_reg & ~gclk_prev_reg;
            go_meta_reg   <= game_over;
            go_sync_reg   <= go_meta_reg;
            state_reg     <= state_next;

            if (state_next == ARMED) begin
                div_reg   <= 8'd0;
                score_reg <= 16'h0000;
            end else if (state_reg == RUNNING && !go_sync_reg && tick_reg) begin
                if (div_reg == 8'(FRAMES_PER_POINT - 1)) begin
                    div_reg <= 8'd0;
                    if (score_reg != 16'h9999) score_reg <= inc_bcd;
                end else begin
                    div_reg <= div_reg + 8'd1;
                end
            end

            // Score is frozen in OVER, so this fires once, one clk after entry
            if (state_reg == OVER && score_reg > high_reg) high_reg <= score_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg <= '0;
            idx_reg     <= 2'd0;
            an_reg      <= 4'b1110;
            seg_reg     <= 8'hC0;
        end else begin
            if (refresh_reg == RW'(REFRESH_DIV - 1)) begin
                refresh_reg <= '0;
                idx_reg     <= idx_reg + 2'd1;
            end else begin
                refresh_reg <= refresh_reg + RW'(1);
            end
            an_reg  <= ~(4'b0001 << idx_reg);
            seg_reg <= blank ? 8'hFF : {1'b1, seg_code};
        end
    end

    assign score_bcd = score_reg;
    assign high_bcd  = high_reg;
    assign phase     = state_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;
endmodule

// File: tb/tb_score_display.sv
// Directed bench: a frame/score model feeds an expectation queue that is
// drained after each frame edge; display digits are checked against a segment table.
module tb_score_display;
    logic        clk = 1'b0;
    logic        rst, game_clk, start, game_over, show_high;
    logic [15:0] score_bcd, high_bcd;
    logic [1:0]  phase;
    logic [3:0]  an;
    logic [7:0]  seg;

    logic        game_clk2, start2;
    logic [15:0] score2, high2;
    logic [1:0]  phase2;
    logic [3:0]  an2;
    logic [7:0]  seg2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  ph;
        logic [15:0] sc;
    } exp_t;
    exp_t exp_q[$];

    int          m_phase, m_div;
    logic [15:0] m_score, m_high;

    always #5 clk = ~clk;

    score_display #(.FRAMES_PER_POINT(6), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .game_clk(game_clk), .start(start),
        .game_over(game_over), .show_high(show_high), .score_bcd(score_bcd),
        .high_bcd(high_bcd), .phase(phase), .an(an), .seg(seg));

    score_display #(.FRAMES_PER_POINT(1), .REFRESH_DIV(4)) dut2 (
        .clk(clk), .rst(rst), .game_clk(game_clk2), .start(start2),
        .game_over(1'b0), .show_high(1'b0), .score_bcd(score2),
        .high_bcd(high2), .phase(phase2), .an(an2), .seg(seg2));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input logic [15:0] v, input int k);
        logic [15:0] upper;
        upper = v >> (4 * k);
        if (k > 0 && upper == 16'h0) return 8'hFF;
        case (upper[3:0])
            4'd0: return 8'hC0;  4'd1: return 8'hF9;
            4'd2: return 8'hA4;  4'd3: return 8'hB0;
            4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;
            4'd8: return 8'h80;  4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // One frame edge on the main DUT: model update, push, drive, pop/compare
    task automatic frame();
        exp_t e;
        if (m_phase == 1 && !game_over) m_phase = 2;
        else if (m_phase == 2 && !game_over) begin
            m_div++;
            if (m_div == 6) begin
                m_div = 0;
                if (m_score != 16'h9999) m_score = int2bcd(bcd2int(m_score) + 1);
            end
        end
        exp_q.push_back('{2'(m_phase), m_score});
        game_clk = 1'b1;
        step(4);
        game_clk = 1'b0;
        step(4);
        e = exp_q.pop_front();
        check("frame_phase", {14'd0, phase}, {14'd0, e.ph});
        check("frame_score", score_bcd, e.sc);
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        m_phase = 1;
        m_div = 0;
        m_score = 16'h0;
        check("armed_phase", {14'd0, phase}, 16'd1);
        check("armed_score", score_bcd, 16'h0);
    endtask

    task automatic collide();
        game_over = 1'b1;
        step(4);
        if (bcd2int(m_score) > bcd2int(m_high)) m_high = m_score;
        m_phase = 3;
        check("over_phase", {14'd0, phase}, 16'd3);
        check("over_high", high_bcd, m_high);
    endtask

    task automatic disp_check(input logic [15:0] v, input string tag);
        int n = 0;
        while (an !== 4'b1110 && n < 20) begin
            step(1);
            n++;
        end
        if (n >= 20) check({tag, "_sync_timeout"}, {12'd0, an}, 16'h000E);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_an"}, {12'd0, an}, {12'd0, ~(4'b0001 << k)});
            check({tag, "_seg"}, {8'd0, seg}, {8'd0, seg_of(v, k)});
            step(4);
        end
    endtask

    task automatic frame2();
        game_clk2 = 1'b1;
        step(2);
        game_clk2 = 1'b0;
        step(2);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; game_clk = 0; start = 0; game_over = 0; show_high = 0;
        game_clk2 = 0; start2 = 0;
        m_phase = 0; m_div = 0; m_score = 16'h0; m_high = 16'h0;
        step(3);
        rst = 1'b0;
        check("rst_phase", {14'd0, phase}, 16'd0);
        check("rst_score", score_bcd, 16'h0);
        check("rst_high", high_bcd, 16'h0);
        check("rst_an", {12'd0, an}, 16'h000E);
        check("rst_seg", {8'd0, seg}, 16'h00C0);
        step(2);

        // Game 1: run to 42, collide, further frames must not score
        do_start();
        frame();
        while (m_score != 16'h0042) frame();
        collide();
        for (int i = 0; i < 3; i++) frame();
        $display("game1 score=%h high=%h", score_bcd, high_bcd);

        // Game 2: game_over still high while armed for two frames
        do_start();
        frame();
        frame();
        game_over = 1'b0;
        step(3);
        frame();
        while (m_score != 16'h0017) frame();
        collide();
        check("high_kept", high_bcd, 16'h0042);
        disp_check(16'h0017, "disp_score17");
        show_high = 1'b1;
        step(1);
        disp_check(16'h0042, "disp_high42");
        show_high = 1'b0;
        $display("game2 score=%h high=%h", score_bcd, high_bcd);

        // Game 3: score 105 for the display walk
        game_over = 1'b0;
        step(3);
        do_start();
        frame();
        while (m_score != 16'h0105) frame();
        collide();
        disp_check(16'h0105, "disp_score105");
        $display("game3 score=%h high=%h", score_bcd, high_bcd);

        // Saturation on the single-frame-per-point instance
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        frame2();
        check("sat_running", {14'd0, phase2}, 16'd2);
        for (int i = 0; i < 9998; i++) frame2();
        check("sat_9998", score2, 16'h9998);
        m_score = 16'h9998;
        for (int i = 0; i < 12; i++) begin
            if (m_score != 16'h9999) m_score = int2bcd(bcd2int(m_score) + 1);
            exp_q.push_back('{2'd2, m_score});
            frame2();
            e = exp_q.pop_front();
            check("sat_score", score2, e.sc);
        end
        $display("saturation score=%h", score2);

        // Reset mid-game clears everything including high score
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("rst2_phase", {14'd0, phase}, 16'd0);
        check("rst2_high", high_bcd, 16'h0);
        check("rst2_score2", score2, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
